// File: rtl/seq_cmp_pkg.sv
// Shared base codes, default scores and the saturating adder for seq_cmp_array.
package seq_cmp_pkg;

  localparam int unsigned BASE_A     = 0;
  localparam int unsigned BASE_C     = 1;
  localparam int unsigned BASE_G     = 2;
  localparam int unsigned BASE_T     = 3;
  localparam int unsigned BASE_N_MIN = 4;

  localparam int SCORE_MATCH_DEF    = 2;
  localparam int SCORE_MISMATCH_DEF = -8;
  localparam int SCORE_N_DEF        = -1;

  // Operands must already fit in w signed bits; the 64-bit sum cannot wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/seq_cmp_array_lane.sv
// Combinational single-lane scorer: N takes priority over match/mismatch.
module seq_cmp_lane
  import seq_cmp_pkg::*;
#(
  parameter int CMP_WIDTH   = 4,
  parameter int SCORE_WIDTH = 16
) (
  input  logic        [CMP_WIDTH-1:0]   nr,
  input  logic        [CMP_WIDTH-1:0]   ns,
  input  logic signed [SCORE_WIDTH-1:0] cfg_match,
  input  logic signed [SCORE_WIDTH-1:0] cfg_mismatch,
  input  logic signed [SCORE_WIDTH-1:0] cfg_n_pen,
  output logic signed [SCORE_WIDTH-1:0] score,
  output logic                          is_match
);

  logic is_n;

  always_comb begin
    is_n     = (32'(nr) >= BASE_N_MIN) || (32'(ns) >= BASE_N_MIN);
    is_match = !is_n && (nr == ns);
    if (is_n)          score = cfg_n_pen;
    else if (is_match) score = cfg_match;
    else               score = cfg_mismatch;
  end

endmodule

// File: rtl/seq_cmp_array.sv
// Multi-lane two-stage base comparator with beat sum, match count and saturating
// per-read total. Optional per-lane mask input when SEQ_CMP_LANE_MASK_EN is defined.
module seq_cmp_array
  import seq_cmp_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int CMP_WIDTH   = 4,
  parameter int SCORE_WIDTH = 16,
  parameter int SUM_WIDTH   = SCORE_WIDTH + $clog2(LANES) + 1,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic signed [SCORE_WIDTH-1:0]    cfg_match,
  input  logic signed [SCORE_WIDTH-1:0]    cfg_mismatch,
  input  logic signed [SCORE_WIDTH-1:0]    cfg_n_pen,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [LANES*CMP_WIDTH-1:0]       s_nr,
  input  logic [LANES*CMP_WIDTH-1:0]       s_ns,
  input  logic                             s_last,
`ifdef SEQ_CMP_LANE_MASK_EN
  input  logic [LANES-1:0]                 s_mask,
`endif
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [LANES*SCORE_WIDTH-1:0]     m_score,
  output logic signed [SUM_WIDTH-1:0]      m_sum,
  output logic [$clog2(LANES):0]           m_match_cnt,
  output logic                             m_last,
  output logic signed [ACC_WIDTH-1:0]      m_total
);

  localparam int CNT_W = $clog2(LANES) + 1;
  localparam int SW    = SCORE_WIDTH;

  logic                         adv;
  logic [LANES*SW-1:0]          lane_score;
  logic [LANES-1:0]             lane_match;
  logic [LANES-1:0]             lane_en;

  logic signed [SW-1:0]         cfg_match_q, cfg_match_d;
  logic signed [SW-1:0]         cfg_mismatch_q, cfg_mismatch_d;
  logic signed [SW-1:0]         cfg_n_pen_q, cfg_n_pen_d;

  logic                         vld_p1_q, vld_p1_d;
  logic                         last_p1_q, last_p1_d;
  logic [LANES*SW-1:0]          score_p1_q, score_p1_d;
  logic [LANES-1:0]             match_p1_q, match_p1_d;

  logic                         vld_p2_q, vld_p2_d;
  logic                         last_p2_q, last_p2_d;
  logic [LANES*SW-1:0]          score_p2_q, score_p2_d;
  logic signed [SUM_WIDTH-1:0]  sum_p2_q, sum_p2_d;
  logic [CNT_W-1:0]             cnt_p2_q, cnt_p2_d;
  logic signed [ACC_WIDTH-1:0]  total_p2_q, total_p2_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;

  logic signed [SUM_WIDTH-1:0]  beat_sum;
  logic [CNT_W-1:0]             beat_cnt;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  total_new;

  assign adv     = ~vld_p2_q | m_ready;
  assign s_ready = adv;

`ifdef SEQ_CMP_LANE_MASK_EN
  assign lane_en = s_mask;
`else
  assign lane_en = '1;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    seq_cmp_lane #(
      .CMP_WIDTH   (CMP_WIDTH),
      .SCORE_WIDTH (SCORE_WIDTH)
    ) u_lane (
      .nr           (s_nr[i*CMP_WIDTH +: CMP_WIDTH]),
      .ns           (s_ns[i*CMP_WIDTH +: CMP_WIDTH]),
      .cfg_match    (cfg_match_q),
      .cfg_mismatch (cfg_mismatch_q),
      .cfg_n_pen    (cfg_n_pen_q),
      .score        (lane_score[i*SW +: SW]),
      .is_match     (lane_match[i])
    );
  end

  // Score registers; a beat accepted alongside cfg_we still sees the old values.
  always_comb begin
    cfg_match_d    = cfg_we ? cfg_match    : cfg_match_q;
    cfg_mismatch_d = cfg_we ? cfg_mismatch : cfg_mismatch_q;
    cfg_n_pen_d    = cfg_we ? cfg_n_pen    : cfg_n_pen_q;
  end

  // Stage 1: masked lane scores, match flags and last.
  always_comb begin
    vld_p1_d   = vld_p1_q;
    last_p1_d  = last_p1_q;
    score_p1_d = score_p1_q;
    match_p1_d = match_p1_q;
    if (adv) begin
      vld_p1_d = s_valid;
      if (s_valid) begin
        last_p1_d  = s_last;
        match_p1_d = lane_match & lane_en;
        for (int i = 0; i < LANES; i++)
          score_p1_d[i*SW +: SW] = lane_en[i] ? lane_score[i*SW +: SW] : '0;
      end
    end
  end

  // Stage 2: beat reduction and running total; this is the output register.
  always_comb begin
    beat_sum = '0;
    beat_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_WIDTH'($signed(score_p1_q[i*SW +: SW]));
      beat_cnt = beat_cnt + CNT_W'(match_p1_q[i]);
    end
    // A last beat leaving this cycle closes its read before the next one adds in.
    acc_base  = (vld_p2_q && last_p2_q) ? '0 : acc_q;
    total_new = ACC_WIDTH'(sat_add(64'(acc_base), 64'(beat_sum), ACC_WIDTH));

    vld_p2_d   = vld_p2_q;
    last_p2_d  = last_p2_q;
    score_p2_d = score_p2_q;
    sum_p2_d   = sum_p2_q;
    cnt_p2_d   = cnt_p2_q;
    total_p2_d = total_p2_q;
    acc_d      = acc_q;
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        last_p2_d  = last_p1_q;
        score_p2_d = score_p1_q;
        sum_p2_d   = beat_sum;
        cnt_p2_d   = beat_cnt;
        total_p2_d = total_new;
        acc_d      = total_new;
      end else if (vld_p2_q && last_p2_q) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_match_q    <= SW'(SCORE_MATCH_DEF);
      cfg_mismatch_q <= SW'(SCORE_MISMATCH_DEF);
      cfg_n_pen_q    <= SW'(SCORE_N_DEF);
      vld_p1_q       <= 1'b0;
      last_p1_q      <= 1'b0;
      score_p1_q     <= '0;
      match_p1_q     <= '0;
      vld_p2_q       <= 1'b0;
      last_p2_q      <= 1'b0;
      score_p2_q     <= '0;
      sum_p2_q       <= '0;
      cnt_p2_q       <= '0;
      total_p2_q     <= '0;
      acc_q          <= '0;
    end else begin
      cfg_match_q    <= cfg_match_d;
      cfg_mismatch_q <= cfg_mismatch_d;
      cfg_n_pen_q    <= cfg_n_pen_d;
      vld_p1_q       <= vld_p1_d;
      last_p1_q      <= last_p1_d;
      score_p1_q     <= score_p1_d;
      match_p1_q     <= match_p1_d;
      vld_p2_q       <= vld_p2_d;
      last_p2_q      <= last_p2_d;
      score_p2_q     <= score_p2_d;
      sum_p2_q       <= sum_p2_d;
      cnt_p2_q       <= cnt_p2_d;
      total_p2_q     <= total_p2_d;
      acc_q          <= acc_d;
    end
  end

  assign m_valid     = vld_p2_q;
  assign m_last      = last_p2_q;
  assign m_score     = score_p2_q;
  assign m_sum       = sum_p2_q;
  assign m_match_cnt = cnt_p2_q;
  assign m_total     = total_p2_q;

endmodule

// File: tb/tb_seq_cmp_array.sv
// Bench for seq_cmp_array (8 lanes, 8-bit total so saturation is reachable);
// directed plan steps followed by a randomized run against a queue-based model.
module tb_seq_cmp_array;

  localparam int LANES = 8;
  localparam int CW    = 4;
  localparam int SW    = 16;
  localparam int SUMW  = SW + $clog2(LANES) + 1;
  localparam int AW    = 8;
  localparam int CNTW  = $clog2(LANES) + 1;
  localparam int ACC_MAX = (1 << (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AW - 1));
  localparam int BUSW  = 1 + LANES*SW + SUMW + CNTW + 1 + AW;
`ifdef SEQ_CMP_LANE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cfg_we;
  logic signed [SW-1:0]     cfg_match, cfg_mismatch, cfg_n_pen;
  logic                     s_valid, s_ready, s_last;
  logic [LANES*CW-1:0]      s_nr, s_ns;
  logic [LANES-1:0]         mask_drv;
  logic                     m_valid, m_ready, m_last;
  logic [LANES*SW-1:0]      m_score;
  logic signed [SUMW-1:0]   m_sum;
  logic [CNTW-1:0]          m_match_cnt;
  logic signed [AW-1:0]     m_total;
`ifdef SEQ_CMP_LANE_MASK_EN
  logic [LANES-1:0]         s_mask;
  assign s_mask = mask_drv;
`endif

  seq_cmp_array #(
    .LANES(LANES), .CMP_WIDTH(CW), .SCORE_WIDTH(SW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .cfg_n_pen(cfg_n_pen),
    .s_valid(s_valid), .s_ready(s_ready), .s_nr(s_nr), .s_ns(s_ns), .s_last(s_last),
`ifdef SEQ_CMP_LANE_MASK_EN
    .s_mask(s_mask),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_score(m_score), .m_sum(m_sum),
    .m_match_cnt(m_match_cnt), .m_last(m_last), .m_total(m_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int exp_match, exp_mm, exp_n, model_acc;
  logic [LANES*SW-1:0] q_score[$];
  int  q_sum[$];
  int  q_cnt[$];
  bit  q_last[$];
  int  out_cnt = 0;
  int  o_sum, o_cnt, o_total;
  bit  o_last;
  logic [LANES*SW-1:0] o_score;
  bit  prev_stall = 0;
  logic [BUSW-1:0] prev_bus;

  function automatic int lane_rule(input int nr, input int ns);
    if (nr > 3 || ns > 3) return exp_n;
    if (nr == ns) return exp_match;
    return exp_mm;
  endfunction

  always @(negedge clk) begin
    logic [LANES*SW-1:0] es;
    logic [LANES*SW-1:0] eq;
    int esum, ecnt, etot, ls, nr_i, ns_i;
    bit elast;
    if (!rst_n) begin
      q_score.delete(); q_sum.delete(); q_cnt.delete(); q_last.delete();
      model_acc = 0; exp_match = 2; exp_mm = -8; exp_n = -1;
      prev_stall = 0;
    end else begin
      chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
      if (prev_stall)
        chk("stall_hold", 64'({m_valid, m_score, m_sum, m_match_cnt, m_last, m_total} === prev_bus), 64'(1));
      if (m_valid && m_ready) begin
        if (q_sum.size() == 0) begin
          chk("unexpected_out", 64'(q_sum.size()), 64'(1));
        end else begin
          eq = q_score.pop_front(); esum = q_sum.pop_front();
          ecnt = q_cnt.pop_front(); elast = q_last.pop_front();
          etot = model_acc + esum;
          if (etot > ACC_MAX) etot = ACC_MAX;
          if (etot < ACC_MIN) etot = ACC_MIN;
          model_acc = elast ? 0 : etot;
          for (int i = 0; i < LANES; i++)
            chk("lane_score", 64'($signed(m_score[i*SW +: SW])), 64'($signed(eq[i*SW +: SW])));
          chk("sum", 64'(m_sum), 64'(esum));
          chk("match_cnt", 64'(m_match_cnt), 64'(ecnt));
          chk("last", 64'(m_last), 64'(elast));
          chk("total", 64'(m_total), 64'(etot));
        end
        o_score = m_score; o_sum = int'(m_sum); o_cnt = int'(m_match_cnt);
        o_total = int'(m_total); o_last = m_last;
        out_cnt++;
      end
      if (s_valid && s_ready) begin
        esum = 0; ecnt = 0; es = '0;
        for (int i = 0; i < LANES; i++) begin
          nr_i = int'(s_nr[i*CW +: CW]);
          ns_i = int'(s_ns[i*CW +: CW]);
          ls = mask_drv[i] ? lane_rule(nr_i, ns_i) : 0;
          es[i*SW +: SW] = SW'(ls);
          esum += ls;
          if (mask_drv[i] && nr_i <= 3 && ns_i <= 3 && nr_i == ns_i) ecnt++;
        end
        q_score.push_back(es); q_sum.push_back(esum);
        q_cnt.push_back(ecnt); q_last.push_back(s_last);
      end
      if (cfg_we) begin
        exp_match = int'(cfg_match); exp_mm = int'(cfg_mismatch); exp_n = int'(cfg_n_pen);
      end
      prev_stall = m_valid && !m_ready;
      prev_bus   = {m_valid, m_score, m_sum, m_match_cnt, m_last, m_total};
    end
  end

  function automatic logic [LANES*CW-1:0] pk(input int l0, l1, l2, l3, l4, l5, l6, l7);
    return {CW'(l7), CW'(l6), CW'(l5), CW'(l4), CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endfunction

  function automatic logic [LANES*CW-1:0] mk_ns(input int k);
    logic [LANES*CW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*CW +: CW] = CW'((i < k) ? (i % 4) : ((i + 1) % 4));
    return r;
  endfunction

  task automatic drive_beat(input logic [LANES*CW-1:0] nr, input logic [LANES*CW-1:0] ns,
                            input bit last, input bit we);
    bit ok; int n;
    s_nr = nr; s_ns = ns; s_last = last; s_valid = 1'b1; cfg_we = we;
    ok = 0; n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1; n++;
      cfg_we = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("accept_in_time", 64'(ok), 64'(1));
  endtask

  task automatic wait_out(input int target, input string tag);
    int n = 0;
    while (out_cnt < target && n < 30) begin
      @(posedge clk); n++;
    end
    chk({tag, "_arrived"}, 64'(out_cnt >= target), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_one(input string tag, input logic [LANES*CW-1:0] nr, input logic [LANES*CW-1:0] ns,
                         input bit last, input bit we, input int e_sum, input int e_cnt, input int e_tot);
    int base;
    base = out_cnt;
    drive_beat(nr, ns, last, we);
    wait_out(base + 1, tag);
    chk({tag, "_sum"}, 64'(o_sum), 64'(e_sum));
    chk({tag, "_cnt"}, 64'(o_cnt), 64'(e_cnt));
    chk({tag, "_total"}, 64'(o_total), 64'(e_tot));
    chk({tag, "_last"}, 64'(o_last), 64'(last));
  endtask

  task automatic set_cfg(input int mt, input int mm, input int np);
    cfg_match = SW'(mt); cfg_mismatch = SW'(mm); cfg_n_pen = SW'(np);
  endtask

  initial begin
    logic [LANES*CW-1:0] acgt, miss;
    int base, k, c, stall_seen, v;
    bit acc;
    acgt = pk(0, 1, 2, 3, 0, 1, 2, 3);
    miss = pk(1, 2, 3, 0, 1, 2, 3, 0);
    rst_n = 1'b0; cfg_we = 1'b0; set_cfg(0, 0, 0);
    s_valid = 1'b0; s_last = 1'b0; s_nr = '0; s_ns = '0; mask_drv = '1; m_ready = 1'b1;
    #1;
    chk("reset_m_valid", 64'(m_valid), 64'(0));
    chk("reset_m_total", 64'(m_total), 64'(0));
    chk("reset_m_sum", 64'(m_sum), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("defaults", acgt, acgt, 1'b1, 1'b0, 16, 8, 16);
    chk("defaults_lane3", 64'($signed(o_score[3*SW +: SW])), 64'(2));

    run_one("mixed", pk(0, 1, 2, 3, 0, 1, 4, 2), pk(0, 1, 2, 3, 1, 2, 3, 15), 1'b1, 1'b0, -10, 4, -10);
    chk("mixed_lane4", 64'($signed(o_score[4*SW +: SW])), 64'(-8));
    chk("mixed_lane6", 64'($signed(o_score[6*SW +: SW])), 64'(-1));

    // Backpressure: five beats with m_ready low in cycles 3..6
    base = out_cnt; k = 0; c = 0; stall_seen = 0;
    while (k < 5 && c < 60) begin
      m_ready = !(c >= 3 && c <= 6);
      s_valid = 1'b1; s_nr = acgt; s_ns = mk_ns(k + 1); s_last = (k == 4);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid && !m_ready && !s_ready) stall_seen++;
      @(posedge clk); #1;
      if (acc) k++;
      c++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    chk("bp_all_accepted", 64'(k), 64'(5));
    chk("bp_stall_seen", 64'(stall_seen > 0), 64'(1));
    wait_out(base + 5, "bp");
    repeat (3) @(posedge clk); #1;
    chk("bp_count", 64'(out_cnt - base), 64'(5));

    // Config update alongside an accepted beat
    set_cfg(1, -4, 0);
    run_one("cfg_old", acgt, miss, 1'b1, 1'b1, -64, 0, -64);
    run_one("cfg_new", acgt, miss, 1'b1, 1'b0, -32, 0, -32);

    // Saturation at 8-bit total
    set_cfg(10, -4, 0); cfg_we = 1'b1;
    @(posedge clk); #1 cfg_we = 1'b0;
    run_one("sat1", acgt, acgt, 1'b0, 1'b0, 80, 8, 80);
    run_one("sat2", acgt, acgt, 1'b0, 1'b0, 80, 8, 127);
    run_one("sat3", acgt, acgt, 1'b1, 1'b0, 80, 8, 127);
    run_one("sat_next", acgt, acgt, 1'b1, 1'b0, 80, 8, 80);

    // Reset with two beats in flight
    s_valid = 1'b1; s_nr = acgt; s_ns = acgt; s_last = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    s_valid = 1'b0;
    chk("pre_rst_valid", 64'(m_valid), 64'(1));
    rst_n = 1'b0; #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_total", 64'(m_total), 64'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("post_rst", acgt, acgt, 1'b1, 1'b0, 16, 8, 16);

    // Randomized traffic, with one reset in the middle
    for (int cyc = 0; cyc < 1500; cyc++) begin
      s_valid = ($urandom % 4) != 0;
      m_ready = ($urandom % 4) != 0;
      s_last  = ($urandom % 4) == 0;
      for (int i = 0; i < LANES; i++) begin
        v = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 4);
        s_nr[i*CW +: CW] = CW'(v);
        if (($urandom % 2) == 0) v = (($urandom % 8) == 0) ? int'($urandom % 16) : int'($urandom % 4);
        s_ns[i*CW +: CW] = CW'(v);
      end
      mask_drv = MASK_EN ? LANES'($urandom) : '1;
      cfg_we = ($urandom % 50) == 0;
      cfg_match = SW'($urandom_range(40) - 20);
      cfg_mismatch = SW'($urandom_range(40) - 20);
      cfg_n_pen = SW'($urandom_range(40) - 20);
      rst_n = (cyc != 700);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1; mask_drv = '1;
    repeat (6) @(posedge clk); #1;
    chk("drain_empty", 64'(q_sum.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
